// File: rtl/decode_issue_stage_if.sv
// decode_issue_stage_if: IF/ID-side inputs and ID/EX-side outputs of the decode/issue stage
interface decode_issue_stage_if #(parameter int CNT_W = 16);
  logic             id_valid;
  logic [16:0]      id_ctrl;
  logic [3:0]       id_aluop;
  logic [4:0]       id_rs, id_rt, id_rd, id_shamt;
  logic [15:0]      id_imm16;
  logic [31:0]      id_rdat1, id_rdat2, id_npc;
  logic             mem_busy, flush;
  logic             ex_valid;
  logic [16:0]      ex_ctrl;
  logic [3:0]       ex_aluop;
  logic [31:0]      ex_rdat1, ex_rdat2, ex_imm32, ex_npc;
  logic [4:0]       ex_shamt, ex_rs, ex_rt, ex_wsel;
  logic             stall_if, halt_pending;
  logic [CNT_W-1:0] bubble_cnt;
  modport master (
    output id_valid, id_ctrl, id_aluop, id_rs, id_rt, id_rd, id_shamt, id_imm16,
           id_rdat1, id_rdat2, id_npc, mem_busy, flush,
    input  ex_valid, ex_ctrl, ex_aluop, ex_rdat1, ex_rdat2, ex_imm32, ex_npc,
           ex_shamt, ex_rs, ex_rt, ex_wsel, stall_if, halt_pending, bubble_cnt
  );
  modport slave (
    input  id_valid, id_ctrl, id_aluop, id_rs, id_rt, id_rd, id_shamt, id_imm16,
           id_rdat1, id_rdat2, id_npc, mem_busy, flush,
    output ex_valid, ex_ctrl, ex_aluop, ex_rdat1, ex_rdat2, ex_imm32, ex_npc,
           ex_shamt, ex_rs, ex_rt, ex_wsel, stall_if, halt_pending, bubble_cnt
  );
endinterface

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: ID/EX register with immediate/wsel decode, load-use bubbles, flush, sticky halt
module decode_issue_stage #(
  parameter int CNT_W    = 16,
  parameter int HALT_REG = 31
) (
  input logic CLK,
  input logic nRST,
  decode_issue_stage_if.slave bus
);
  logic [16:0] c;
  logic        uses_rt, lu, bubble, count;
  logic [4:0]  wsel;
  logic [31:0] imm32;
  always_comb begin
    c       = bus.id_ctrl;
    uses_rt = (c[14:13] == 2'b00) | c[0] | c[1] | c[5];
    wsel    = c[16:15] == 2'b00 ? bus.id_rt :
              c[16:15] == 2'b01 ? bus.id_rd :
              c[16:15] == 2'b10 ? 5'(HALT_REG) : 5'd0;
    imm32   = c[10] ? {bus.id_imm16, 16'h0} :
              c[3]  ? {{16{bus.id_imm16[15]}}, bus.id_imm16} : {16'h0, bus.id_imm16};
    lu      = bus.id_valid & bus.ex_valid & bus.ex_ctrl[4] & (bus.ex_wsel != 5'd0) &
              ((bus.ex_wsel == bus.id_rs) | (uses_rt & (bus.ex_wsel == bus.id_rt)));
    bus.stall_if = lu & ~bus.flush & ~bus.halt_pending;
    bubble  = bus.flush | bus.halt_pending | lu | ~bus.id_valid;
    // only flush and real load-use stalls are counted; idle and halt bubbles are not
    count   = bus.flush | bus.stall_if;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_ctrl      <= '0;
      bus.ex_aluop     <= '0;
      bus.ex_rdat1     <= '0;
      bus.ex_rdat2     <= '0;
      bus.ex_imm32     <= '0;
      bus.ex_npc       <= '0;
      bus.ex_shamt     <= '0;
      bus.ex_rs        <= '0;
      bus.ex_rt        <= '0;
      bus.ex_wsel      <= '0;
      bus.halt_pending <= 1'b0;
      bus.bubble_cnt   <= '0;
    end else if (!bus.mem_busy) begin
      bus.ex_valid <= ~bubble;
      bus.ex_ctrl  <= bubble ? '0 : c;
      bus.ex_aluop <= bubble ? '0 : bus.id_aluop;
      bus.ex_rdat1 <= bubble ? '0 : bus.id_rdat1;
      bus.ex_rdat2 <= bubble ? '0 : bus.id_rdat2;
      bus.ex_imm32 <= bubble ? '0 : imm32;
      bus.ex_npc   <= bubble ? '0 : bus.id_npc;
      bus.ex_shamt <= bubble ? '0 : bus.id_shamt;
      bus.ex_rs    <= bubble ? '0 : bus.id_rs;
      bus.ex_rt    <= bubble ? '0 : bus.id_rt;
      bus.ex_wsel  <= bubble ? '0 : wsel;
      if (~bubble & c[11]) bus.halt_pending <= 1'b1;
      if (count & ~&bus.bubble_cnt) bus.bubble_cnt <= bus.bubble_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: scoreboard bench for decode_issue_stage, plus a CNT_W=2 copy for saturation
module tb_decode_issue_stage;
  localparam logic [16:0] ADDI = 17'h0200C, LW = 17'h0211C, ADD = 17'h08004, SW = 17'h02028;
  localparam logic [16:0] ORI = 17'h02004, LUI = 17'h02404, JAL = 17'h100C4, HALT = 17'h00800;
  typedef struct {
    logic        v;
    logic [16:0] ctrl;
    logic [4:0]  wsel;
    logic [31:0] imm, npc;
    logic [15:0] cnt;
    logic        halt;
  } exp_t;
  logic CLK = 1'b0, nRST = 1'b0;
  int n_cmp = 0, n_bad = 0;
  exp_t sb[$];
  decode_issue_stage_if #(.CNT_W(16)) b ();
  decode_issue_stage_if #(.CNT_W(2))  b2 ();
  decode_issue_stage #(.CNT_W(16), .HALT_REG(31)) dut (.CLK(CLK), .nRST(nRST), .bus(b.slave));
  decode_issue_stage #(.CNT_W(2), .HALT_REG(31)) dut2 (.CLK(CLK), .nRST(nRST), .bus(b2.slave));
  assign b2.id_valid = b.id_valid;
  assign b2.id_ctrl  = b.id_ctrl;
  assign b2.id_aluop = b.id_aluop;
  assign b2.id_rs    = b.id_rs;
  assign b2.id_rt    = b.id_rt;
  assign b2.id_rd    = b.id_rd;
  assign b2.id_shamt = b.id_shamt;
  assign b2.id_imm16 = b.id_imm16;
  assign b2.id_rdat1 = b.id_rdat1;
  assign b2.id_rdat2 = b.id_rdat2;
  assign b2.id_npc   = b.id_npc;
  assign b2.mem_busy = b.mem_busy;
  assign b2.flush    = b.flush;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t mk(logic v, logic [16:0] ctrl, logic [4:0] wsel, logic [31:0] imm,
                              logic [31:0] npc, logic [15:0] cnt, logic halt);
    exp_t e;
    e.v = v; e.ctrl = ctrl; e.wsel = wsel; e.imm = imm; e.npc = npc; e.cnt = cnt; e.halt = halt;
    return e;
  endfunction
  function automatic exp_t bub(logic [15:0] cnt, logic halt);
    return mk(1'b0, '0, '0, '0, '0, cnt, halt);
  endfunction
  task automatic pres(input logic v, input logic [16:0] ctrl, input logic [4:0] rs, rt, rd,
                      input logic [15:0] imm, input logic [31:0] npc, input logic fl, busy);
    b.id_valid = v; b.id_ctrl = ctrl; b.id_rs = rs; b.id_rt = rt; b.id_rd = rd;
    b.id_imm16 = imm; b.id_npc = npc; b.flush = fl; b.mem_busy = busy;
    b.id_aluop = 4'($urandom); b.id_shamt = 5'($urandom);
    b.id_rdat1 = $urandom; b.id_rdat2 = $urandom;
  endtask
  task automatic step(input exp_t e);
    exp_t g;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    g = sb.pop_front();
    chk("ex_valid", 32'(b.ex_valid), 32'(g.v));
    chk("ex_ctrl", 32'(b.ex_ctrl), 32'(g.ctrl));
    chk("ex_wsel", 32'(b.ex_wsel), 32'(g.wsel));
    chk("ex_imm32", b.ex_imm32, g.imm);
    chk("ex_npc", b.ex_npc, g.npc);
    chk("bubble_cnt", 32'(b.bubble_cnt), 32'(g.cnt));
    chk("bubble_cnt_sat", 32'(b2.bubble_cnt), g.cnt > 16'd3 ? 32'd3 : 32'(g.cnt));
    chk("halt_pending", 32'(b.halt_pending), 32'(g.halt));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(b.ex_valid), 32'd0);
    chk({tag, "_ctrl"}, 32'(b.ex_ctrl), 32'd0);
    chk({tag, "_aluop"}, 32'(b.ex_aluop), 32'd0);
    chk({tag, "_rdat1"}, b.ex_rdat1, 32'd0);
    chk({tag, "_imm"}, b.ex_imm32, 32'd0);
    chk({tag, "_wsel"}, 32'(b.ex_wsel), 32'd0);
    chk({tag, "_halt"}, 32'(b.halt_pending), 32'd0);
    chk({tag, "_cnt"}, 32'(b.bubble_cnt), 32'd0);
    chk({tag, "_stall"}, 32'(b.stall_if), 32'd0);
  endtask
  initial begin
    pres(1'b0, '0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 1'b0, 1'b0);
    #12 chk_zero("reset");
    @(negedge CLK) nRST = 1'b1;
    pres(1'b1, ADDI, 5'd0, 5'd2, 5'd0, 16'h0005, 32'h4, 1'b0, 1'b0);
    step(mk(1'b1, ADDI, 5'd2, 32'h5, 32'h4, 16'd0, 1'b0));
    pres(1'b1, LW, 5'd4, 5'd3, 5'd0, 16'h0, 32'h8, 1'b0, 1'b0);
    step(mk(1'b1, LW, 5'd3, 32'h0, 32'h8, 16'd0, 1'b0));
    pres(1'b1, ADD, 5'd3, 5'd6, 5'd5, 16'h0, 32'hC, 1'b0, 1'b0);
    #1 chk("stall_lu", 32'(b.stall_if), 32'd1);
    step(bub(16'd1, 1'b0));
    #1 chk("stall_after_bubble", 32'(b.stall_if), 32'd0);
    step(mk(1'b1, ADD, 5'd5, 32'h0, 32'hC, 16'd1, 1'b0));
    pres(1'b1, LW, 5'd4, 5'd3, 5'd0, 16'h0, 32'h10, 1'b0, 1'b0);
    step(mk(1'b1, LW, 5'd3, 32'h0, 32'h10, 16'd1, 1'b0));
    pres(1'b1, SW, 5'd1, 5'd3, 5'd0, 16'h0004, 32'h14, 1'b1, 1'b0);
    #1 chk("stall_flush", 32'(b.stall_if), 32'd0);
    step(bub(16'd2, 1'b0));
    pres(1'b1, HALT, 5'd0, 5'd0, 5'd0, 16'h0, 32'h18, 1'b1, 1'b0);
    step(bub(16'd3, 1'b0));
    pres(1'b1, LW, 5'd4, 5'd0, 5'd0, 16'h0, 32'h1C, 1'b0, 1'b0);
    step(mk(1'b1, LW, 5'd0, 32'h0, 32'h1C, 16'd3, 1'b0));
    pres(1'b1, ADD, 5'd0, 5'd0, 5'd7, 16'h0, 32'h20, 1'b0, 1'b0);
    #1 chk("stall_r0", 32'(b.stall_if), 32'd0);
    step(mk(1'b1, ADD, 5'd7, 32'h0, 32'h20, 16'd3, 1'b0));
    pres(1'b1, LW, 5'd4, 5'd3, 5'd0, 16'h0, 32'h24, 1'b0, 1'b0);
    step(mk(1'b1, LW, 5'd3, 32'h0, 32'h24, 16'd3, 1'b0));
    pres(1'b1, ADDI, 5'd1, 5'd3, 5'd0, 16'hFFFF, 32'h28, 1'b0, 1'b0);
    #1 chk("stall_imm_rt", 32'(b.stall_if), 32'd0);
    step(mk(1'b1, ADDI, 5'd3, 32'hFFFF_FFFF, 32'h28, 16'd3, 1'b0));
    pres(1'b1, ORI, 5'd1, 5'd4, 5'd0, 16'hFFFF, 32'h2C, 1'b0, 1'b0);
    step(mk(1'b1, ORI, 5'd4, 32'h0000_FFFF, 32'h2C, 16'd3, 1'b0));
    pres(1'b1, LUI, 5'd0, 5'd5, 5'd0, 16'h1234, 32'h30, 1'b0, 1'b0);
    step(mk(1'b1, LUI, 5'd5, 32'h1234_0000, 32'h30, 16'd3, 1'b0));
    pres(1'b1, JAL, 5'd0, 5'd0, 5'd0, 16'h0, 32'h100, 1'b0, 1'b0);
    step(mk(1'b1, JAL, 5'd31, 32'h0, 32'h100, 16'd3, 1'b0));
    for (int i = 0; i < 3; i++) begin
      pres(1'b1, ADDI, 5'd1, 5'd9, 5'd0, 16'h0007, 32'h104, i == 2, 1'b1);
      step(mk(1'b1, JAL, 5'd31, 32'h0, 32'h100, 16'd3, 1'b0));
    end
    pres(1'b0, ADD, 5'd1, 5'd2, 5'd3, 16'h0, 32'h104, 1'b0, 1'b0);
    step(bub(16'd3, 1'b0));
    pres(1'b1, HALT, 5'd0, 5'd0, 5'd0, 16'h0, 32'h108, 1'b0, 1'b0);
    step(mk(1'b1, HALT, 5'd0, 32'h0, 32'h108, 16'd3, 1'b1));
    pres(1'b1, ADD, 5'd1, 5'd2, 5'd8, 16'h0, 32'h10C, 1'b0, 1'b0);
    step(bub(16'd3, 1'b1));
    for (int i = 0; i < 5; i++) begin
      pres(1'b1, ADD, 5'd1, 5'd2, 5'd8, 16'h0, 32'h110, 1'b1, 1'b0);
      step(bub(16'(4 + i), 1'b1));
    end
    #2 nRST = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge CLK) nRST = 1'b1;
    pres(1'b1, LW, 5'd4, 5'd3, 5'd0, 16'h0, 32'h40, 1'b0, 1'b0);
    step(mk(1'b1, LW, 5'd3, 32'h0, 32'h40, 16'd0, 1'b0));
    pres(1'b1, ADD, 5'd3, 5'd6, 5'd5, 16'h0, 32'h44, 1'b0, 1'b0);
    #1 chk("stall_pre_reset", 32'(b.stall_if), 32'd1);
    #1 nRST = 1'b0;
    #1 chk_zero("reset_mid_stall");
    @(negedge CLK) nRST = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Decode-to-execute boundary of each core's pipeline. Sits directly downstream of the control unit.
- Registers the control unit's decoded control bundle, together with IF/ID operand fields, into the ID/EX register.
- Forms the 32-bit immediate and write-select register.
- Detects load-use hazards and inserts bubbles, applies branch/jump flushes, and latches a sticky halt.
- Keeps a saturating bubble counter for performance monitoring.

Parameters:
CNT_W, 16, width of the bubble performance counter
HALT_REG, 31, register index written when RegDst=2'b10 (jal)

Ports:
CLK  input  1  core clock; all state on rising edge
nRST  input  1  asynchronous active-low reset
id_valid  input  1  IF/ID holds a real instruction
id_ctrl  input  17  control bundle from control unit: [0]beq [1]bne [2]RegWr [3]ExtOp [4]dREN [5]dWEN [6]jal [7]jump [8]mem2reg [9]jr [10]lui [11]halt [12]datomic [14:13]ALUSrc [16:15]RegDst
id_aluop  input  4  ALUop from control unit
id_rs, id_rt, id_rd  input  5 each  register fields of IF/ID instruction
id_shamt  input  5  shift amount
id_imm16  input  16  immediate field
id_rdat1, id_rdat2  input  32 each  register file read data
id_npc  input  32  PC+4 of the IF/ID instruction
mem_busy  input  1  memory stage waiting on dhit; whole pipe holds
flush  input  1  branch/jump taken, resolved downstream; squash ID
ex_valid  output  1  ID/EX holds a real instruction
ex_ctrl  output  17  registered id_ctrl, same bit map
ex_aluop  output  4  registered ALUop
ex_rdat1, ex_rdat2  output  32 each  registered operands
ex_imm32  output  32  extended immediate
ex_shamt  output  5  registered shamt
ex_rs, ex_rt  output  5 each  for downstream forwarding
ex_wsel  output  5  destination register
ex_npc  output  32  registered PC+4
stall_if  output  1  hold PC and IF/ID this cycle (combinational)
halt_pending  output  1  sticky; a halt has entered EX
bubble_cnt  output  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset (nRST low, asynchronous): all ex_* outputs are 0, ex_aluop is 0 (ALU_SLL), halt_pending is 0, and bubble_cnt is 0.
- Combinational decode:
  - uses_rt = (ALUSrc==2'b00) | beq | bne | dWEN.
  - wsel: RegDst 00 gives rt, 01 gives rd, 10 gives HALT_REG, and 11 gives 0.
  - imm32: lui gives {imm16,16'h0}; otherwise ExtOp gives sign-extended imm16; otherwise zero-extended imm16.
- Load-use hazard: lu = id_valid & ex_valid & ex_ctrl[4] & (ex_wsel!=0) & ((ex_wsel==id_rs) | (uses_rt & ex_wsel==id_rt)).
- stall_if = lu & ~flush & ~halt_pending. When mem_busy is high, stall_if is still driven by lu; the fetch side also holds on mem_busy.
- Per-edge priority (highest first):
  1. mem_busy: ID/EX and counters hold all values.
  2. flush: load a bubble.
  3. halt_pending: load a bubble.
  4. lu: load a bubble; IF/ID holds, so the same instruction re-evaluates next cycle.
  5. ~id_valid: load a bubble.
  6. Otherwise: load the decoded instruction with ex_valid=1.
- Bubble: ex_valid=0, ex_ctrl=0, ex_aluop=0, and all data fields 0. bubble_cnt increments on every bubble load caused by flush or lu, saturating at all-ones. Idle bubbles (~id_valid, halt_pending) do not count.
- Halt:
  - halt_pending sets on the edge where an instruction with ctrl[11]=1 is loaded into ID/EX.
  - Cleared only by reset.
  - The halt itself propagates normally.
- A flush takes priority over halt capture: a halt squashed by flush does not set halt_pending.
- Simultaneous flush and lu: flush wins. stall_if=0 and the counter increments once.
- Register $0 never creates a hazard.
- Reset mid-stall: all state clears immediately and stall_if deasserts because ex_valid=0.
- Latency: one cycle from ID inputs to ex_* outputs. No internal buffering beyond ID/EX.

Test Plan:
- ADDI $2,$0,5 (ExtOp, imm 16'h0005), id_valid, no hazards → next cycle ex_valid=1, ex_wsel=2, ex_imm32=32'h00000005, bubble_cnt=0.
- LW $3,0($4) loaded, then ADD $5,$3,$6 presented → stall_if=1 for one cycle, ex_valid=0, bubble_cnt=1; next cycle ADD enters with ex_wsel=5.
- LW $3 in EX, SW $3,4($1) (uses_rt) present with flush=1 → stall_if=0, bubble loaded, bubble_cnt=1, halt_pending=0.
- ORI imm 16'hFFFF (ExtOp=0) → ex_imm32=32'h0000FFFF. LUI imm 16'h1234 → 32'h12340000. JAL → ex_wsel=31, ex_npc=id_npc.
- HALT loaded → halt_pending=1 from the next cycle onward. A following valid ADD yields ex_valid=0. nRST pulse low mid-run → all outputs 0 asynchronously.
- mem_busy=1 for 3 cycles with a new instruction presented → ex_* unchanged throughout. Force CNT_W=2 with 5 flush bubbles → bubble_cnt saturates at 2'b11.
